// File: rtl/control_unit.sv
// Instruction-sequencing controller: fetch (T0-T2), decode (T3) and ALU
// execute (T4-T5) for a single-bus datapath, with a HALT state left only by clr.
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        Mem_rdy,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        Zlowout,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Rout,
    output logic [3:0]  Rout_sel,
    output logic        Rin,
    output logic [3:0]  Rin_sel,
    output logic [3:0]  ALU_op,
    output logic        Run,
    output logic [2:0]  State
);

    // state | meaning
    // T0    | PC -> MAR, PC+1 -> Z
    // T1    | Z -> PC, memory read into MDR; waits here for Mem_rdy
    // T2    | MDR -> IR
    // T3    | decode; ALU ops load Y from Rb, halt/no-op strobe nothing
    // T4    | Rc on bus, ALU result -> Z
    // T5    | Z -> Ra
    // HALT  | idle with Run low until clr
    typedef enum logic [2:0] {
        T0     = 3'b000,
        T1     = 3'b001,
        T2     = 3'b010,
        T3     = 3'b011,
        T4     = 3'b100,
        T5     = 3'b101,
        HALT   = 3'b110,
        UNUSED = 3'b111
    } state_e;

    localparam logic [4:0] OP_HALT = 5'b11011;

    state_e     state_q;
    state_e     state_d;
    logic [4:0] opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       is_alu;
    logic [3:0] alu_code;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];

    always_comb begin
        is_alu   = 1'b1;
        alu_code = 4'b0000;
        case (opcode)
            5'b00011: alu_code = 4'b0000;
            5'b00100: alu_code = 4'b0001;
            5'b00101: alu_code = 4'b0010;
            5'b00110: alu_code = 4'b0011;
            5'b00111: alu_code = 4'b0100;
            5'b01000: alu_code = 4'b0101;
            5'b01001: alu_code = 4'b0110;
            5'b01010: alu_code = 4'b0111;
            5'b01011: alu_code = 4'b1000;
            default:  is_alu   = 1'b0;
        endcase
    end

    always_comb begin
        state_d = T0;
        case (state_q)
            T0:      state_d = T1;
            T1:      state_d = Mem_rdy ? T2 : T1;
            T2:      state_d = T3;
            T3: begin
                if (is_alu)
                    state_d = T4;
                else if (opcode == OP_HALT)
                    state_d = HALT;
                else
                    state_d = T0;
            end
            T4:      state_d = T5;
            T5:      state_d = T0;
            HALT:    state_d = HALT;
            default: state_d = T0;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            state_q <= T0;
        else
            state_q <= state_d;
    end

    // Outputs decode the live state and IR; clr gates them so the bus is quiet
    // the instant reset is applied, even though T0 itself carries strobes.
    always_comb begin
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Rout     = 1'b0;
        Rout_sel = 4'b0000;
        Rin      = 1'b0;
        Rin_sel  = 4'b0000;
        ALU_op   = 4'b0000;
        Run      = 1'b1;
        if (!clr) begin
            case (state_q)
                T0: begin
                    PCout = 1'b1;
                    MARin = 1'b1;
                    IncPC = 1'b1;
                    Zin   = 1'b1;
                end
                T1: begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                    Read    = 1'b1;
                    MDRin   = 1'b1;
                end
                T2: begin
                    MDRout = 1'b1;
                    IRin   = 1'b1;
                end
                T3: begin
                    if (is_alu) begin
                        Rout     = 1'b1;
                        Rout_sel = rb;
                        Yin      = 1'b1;
                    end
                end
                T4: begin
                    Rout     = 1'b1;
                    Rout_sel = rc;
                    Zin      = 1'b1;
                    ALU_op   = alu_code;
                end
                T5: begin
                    Zlowout = 1'b1;
                    Rin     = 1'b1;
                    Rin_sel = ra;
                end
                HALT:    Run = 1'b0;
                default: Run = 1'b1;
            endcase
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed instruction sequences push the
// expected per-cycle outputs; a monitor compares them on each falling edge.
module tb_control_unit;

    logic        clk;
    logic        clr;
    logic [31:0] IR;
    logic        Mem_rdy;
    logic        PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic        Rout;
    logic [3:0]  Rout_sel;
    logic        Rin;
    logic [3:0]  Rin_sel;
    logic [3:0]  ALU_op;
    logic        Run;
    logic [2:0]  State;

    control_unit dut (
        .clk(clk), .clr(clr), .IR(IR), .Mem_rdy(Mem_rdy),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
        .Zlowout(Zlowout), .PCin(PCin), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .Rout(Rout), .Rout_sel(Rout_sel), .Rin(Rin), .Rin_sel(Rin_sel),
        .ALU_op(ALU_op), .Run(Run), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [28:0] vec_t;

    // strobe field order: PCout MARin IncPC Zin Zlowout PCin Read MDRin MDRout IRin Yin
    localparam logic [10:0] S_T0   = 11'b11110000000;
    localparam logic [10:0] S_T1   = 11'b00001111000;
    localparam logic [10:0] S_T2   = 11'b00000000110;
    localparam logic [10:0] S_YIN  = 11'b00000000001;
    localparam logic [10:0] S_ZIN  = 11'b00010000000;
    localparam logic [10:0] S_ZLO  = 11'b00001000000;
    localparam logic [10:0] S_NONE = 11'b00000000000;

    vec_t obs;
    assign obs = {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin,
                  Rout, Rout_sel, Rin, Rin_sel, ALU_op, Run, State};

    vec_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    function automatic vec_t mk(input logic [10:0] s, input logic rout, input logic [3:0] rsel,
                                input logic rin, input logic [3:0] isel, input logic [3:0] alu,
                                input logic run, input logic [2:0] st);
        return {s, rout, rsel, rin, isel, alu, run, st};
    endfunction

    vec_t v_rst;
    vec_t v_halt;
    initial begin
        v_rst  = mk(S_NONE, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 3'b000);
        v_halt = mk(S_NONE, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 3'b110);
    end

    // Drive inputs just after a rising edge, queue the expectation for this
    // cycle, then move to just after the next rising edge.
    task automatic step(input logic c, input logic m, input vec_t e);
        clr     = c;
        Mem_rdy = m;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string name, input vec_t e);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, obs, e);
        end
    endtask

    task automatic fetch(input logic [31:0] ir, input int stalls);
        IR = ir;
        step(1'b0, 1'b1, mk(S_T0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 3'b000));
        for (int i = 0; i < stalls; i++)
            step(1'b0, 1'b0, mk(S_T1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 3'b001));
        step(1'b0, 1'b1, mk(S_T1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 3'b001));
        step(1'b0, 1'b1, mk(S_T2, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 3'b010));
    endtask

    task automatic run_alu(input logic [31:0] ir, input logic [3:0] ra, input logic [3:0] rb,
                           input logic [3:0] rc, input logic [3:0] alu, input int stalls);
        fetch(ir, stalls);
        step(1'b0, 1'b1, mk(S_YIN, 1'b1, rb, 1'b0, 4'h0, 4'h0, 1'b1, 3'b011));
        step(1'b0, 1'b1, mk(S_ZIN, 1'b1, rc, 1'b0, 4'h0, alu, 1'b1, 3'b100));
        step(1'b0, 1'b1, mk(S_ZLO, 1'b0, 4'h0, 1'b1, ra, 4'h0, 1'b1, 3'b101));
    endtask

    always @(negedge clk) begin
        cyc++;
        if (sb_q.size() > 0) begin
            vec_t e;
            e = sb_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL cycle %0d: got %h (state %b) expected %h (state %b)",
                         cyc, obs, State, e, e[2:0]);
            end
        end
    end

    // Bus-driver exclusivity and zero-select rules on every cycle.
    always @(negedge clk) begin
        checks++;
        if ($countones({Zlowout, MDRout, PCout, Rout}) > 1 || (Rout && Rin)) begin
            errors++;
            $display("FAIL exclusivity cycle %0d: Zlowout=%b MDRout=%b PCout=%b Rout=%b Rin=%b",
                     cyc, Zlowout, MDRout, PCout, Rout, Rin);
        end
        checks++;
        if ((!Rout && Rout_sel != 4'h0) || (!Rin && Rin_sel != 4'h0)) begin
            errors++;
            $display("FAIL zero_select cycle %0d: Rout=%b Rout_sel=%h Rin=%b Rin_sel=%h",
                     cyc, Rout, Rout_sel, Rin, Rin_sel);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr     = 1'b1;
        IR      = 32'h40918000;
        Mem_rdy = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, v_rst);
        step(1'b1, 1'b1, v_rst);

        // shra R1,R2,R3 then and R1,R2,R3 with a 3-cycle memory stall
        run_alu(32'h40918000, 4'h1, 4'h2, 4'h3, 4'b0101, 0);
        run_alu(32'h28918000, 4'h1, 4'h2, 4'h3, 4'b0010, 3);
        // add R5,R6,R7 and rol R15,R0,R9
        run_alu(32'h1AB38000, 4'h5, 4'h6, 4'h7, 4'b0000, 0);
        run_alu(32'h5F848000, 4'hF, 4'h0, 4'h9, 4'b1000, 1);

        // undefined opcode 11111: empty T3 then straight back to T0
        fetch(32'hF8918000, 0);
        step(1'b0, 1'b1, mk(S_NONE, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 3'b011));

        // sub R1,R2,R3 aborted by clr in the middle of T4
        fetch(32'h20918000, 0);
        step(1'b0, 1'b1, mk(S_YIN, 1'b1, 4'h2, 1'b0, 4'h0, 4'h0, 1'b1, 3'b011));
        check_now("t4_before_clr", mk(S_ZIN, 1'b1, 4'h3, 1'b0, 4'h0, 4'b0001, 1'b1, 3'b100));
        #2;
        clr = 1'b1;
        #1;
        check_now("t4_async_clr", v_rst);
        sb_q.push_back(v_rst);
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, v_rst);

        // halt opcode 11011: HALT for 10 cycles, then clr recovers
        fetch(32'hD8000000, 0);
        step(1'b0, 1'b1, mk(S_NONE, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 3'b011));
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, v_halt);
        step(1'b1, 1'b1, v_rst);
        step(1'b0, 1'b1, mk(S_T0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 3'b000));
        step(1'b0, 1'b1, mk(S_T1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 3'b001));

        for (int i = 0; i < 20 && sb_q.size() > 0; i++)
            @(negedge clk);
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0 pending", sb_q.size());
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
